// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-outstanding memory bus between instruction fetch and data load/store.
// Data has priority; a starvation counter forces fetch through after MAX_WAIT back-to-back data wins.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                if_flush,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_d;
    logic                r_drop;
    logic [CNT_W-1:0]    r_starve_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_starved;
    logic                w_pick_d;
    logic                w_pick_if;
    logic                w_resp;

    assign w_starved = (r_starve_cnt == CNT_W'(MAX_WAIT));
    assign w_pick_d  = d_req && !(if_req && w_starved);
    assign w_pick_if = if_req && !w_pick_d;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (d_req || if_req) w_state_nxt = S_REQ;
            S_REQ:   if (mem_gnt)         w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_rvalid)      w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // Winner's request is captured in IDLE so the bus sees stable values through REQ.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner_d    <= 1'b0;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else if (r_state == S_IDLE) begin
            r_drop <= 1'b0;
            if (w_pick_d) begin
                r_owner_d   <= 1'b1;
                r_mem_addr  <= d_addr;
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_wdata <= d_wdata;
            end else if (w_pick_if) begin
                r_owner_d   <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_wdata <= '0;
            end
            if (!if_req || w_pick_if)
                r_starve_cnt <= '0;
            else if (!w_starved)
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end else begin
            if (r_state == S_WAIT && mem_rvalid)
                r_drop <= 1'b0;
            else if (if_flush && !r_owner_d)
                r_drop <= 1'b1;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign w_resp    = reset_n && (r_state == S_WAIT) && mem_rvalid;

    // Handshake pulses are gated by reset_n so an abandoned transaction never completes.
    always_comb begin
        mem_req   = (r_state == S_REQ);
        busy      = (r_state != S_IDLE);
        if_gnt    = reset_n && (r_state == S_REQ) && mem_gnt && !r_owner_d;
        d_gnt     = reset_n && (r_state == S_REQ) && mem_gnt &&  r_owner_d;
        if_rvalid = w_resp && !r_owner_d && !r_drop && !if_flush;
        d_rvalid  = w_resp && r_owner_d;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_flush(if_flush),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        s_if_req;  logic [31:0] s_if_addr; logic s_if_flush;
        logic        s_d_req;   logic s_d_we; logic [3:0] s_d_be;
        logic [31:0] s_d_addr;  logic [31:0] s_d_wdata;
        logic        s_mem_gnt; logic s_mem_rvalid; logic [31:0] s_mem_rdata;
        logic        e_if_gnt;  logic e_if_rvalid; logic [31:0] e_if_rdata;
        logic        e_d_gnt;   logic e_d_rvalid;  logic [31:0] e_d_rdata;
        logic        e_mem_req; logic e_mem_we; logic [3:0] e_mem_be;
        logic [31:0] e_mem_addr; logic [31:0] e_mem_wdata; logic e_busy;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    // One transaction starting from IDLE: request, bus grant, one empty wait cycle, response.
    task automatic txn(input bit is_d, input logic [31:0] addr, input logic [31:0] rd,
                       input bit fl_idle, input bit fl_req, input bit fl_wait, input bit fl_rv,
                       input bit exp_rv, input string nm);
        @(posedge clk); #1;
        if (is_d) begin d_req = 1; d_we = 0; d_be = 4'hF; d_addr = addr; end
        else      begin if_req = 1; if_addr = addr; end
        if_flush = fl_idle;
        @(posedge clk); #1;
        mem_gnt = 1; if_flush = fl_req;
        @(negedge clk);
        chk({nm, "_addr"}, mem_addr, addr);
        chk({nm, "_gnt"}, {if_gnt, d_gnt}, is_d ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        if_req = 0; d_req = 0; mem_gnt = 0; if_flush = fl_wait;
        @(posedge clk); #1;
        if_flush = fl_rv; mem_rvalid = 1; mem_rdata = rd;
        @(negedge clk);
        chk({nm, "_rvalid"}, {if_rvalid, d_rvalid}, exp_rv ? (is_d ? 2'b01 : 2'b10) : 2'b00);
        chk({nm, "_rdata"}, is_d ? d_rdata : if_rdata, exp_rv ? rd : 32'h0);
        @(posedge clk); #1;
        mem_rvalid = 0; mem_rdata = 0; if_flush = 0;
        @(negedge clk);
        chk({nm, "_idle"}, busy, 1'b0);
    endtask

    // Reference model state (transaction view) and requester agents for the random phase
    int          m_out;
    bit          m_own_d, m_drop;
    int          m_wins;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    bit          f_pend, f_cool, dp, d_cool;
    logic [31:0] f_a, da, dwd;
    logic        dw;
    logic [3:0]  dbe;
    logic        e_req, e_busy, e_ig, e_dg, e_ir, e_dr;

    bit   ord [11];
    bit   ord_exp [11];
    int   n;
    bit   fdone, sg_i, sg_d;

    initial begin
        vecs[0]  = '{1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h10, 0, 1};
        vecs[2]  = '{1, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h10, 0, 1};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBAD0BAD0,      0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093,      0, 1, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 32'h20, 0, 1, 1, 4'hF, 32'h10000004, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 32'h20, 0, 1, 1, 4'hF, 32'h10000004, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 1, 0, 0,
                     1, 1, 4'hF, 32'h10000004, 32'hDEADBEEF, 1};
        vecs[8]  = '{1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A,     0, 0, 0, 0, 1, 32'h5A5A,     0, 0, 0, 0, 0, 1};
        vecs[9]  = '{1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0,            1, 0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h20, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555,      0, 1, 32'hAAAA5555, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h100, 0, 1};
        vecs[15] = '{0, 0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 0, 0,        0, 0, 0, 1, 0, 0,            1, 0, 4'hF, 32'h100, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFF,            0, 0, 0, 0, 1, 32'hFF,       0, 0, 0, 0, 0, 1};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0};

        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid}, 6'b0);
        chk("rst_bus", {mem_we, mem_be, mem_wdata}, 37'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        @(posedge clk); #1;
        reset_n = 1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].s_if_req; if_addr = vecs[i].s_if_addr; if_flush = vecs[i].s_if_flush;
            d_req = vecs[i].s_d_req; d_we = vecs[i].s_d_we; d_be = vecs[i].s_d_be;
            d_addr = vecs[i].s_d_addr; d_wdata = vecs[i].s_d_wdata;
            mem_gnt = vecs[i].s_mem_gnt; mem_rvalid = vecs[i].s_mem_rvalid; mem_rdata = vecs[i].s_mem_rdata;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), {if_gnt, d_gnt}, {vecs[i].e_if_gnt, vecs[i].e_d_gnt});
            chk($sformatf("v%0d_rvalid", i), {if_rvalid, d_rvalid}, {vecs[i].e_if_rvalid, vecs[i].e_d_rvalid});
            chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            chk($sformatf("v%0d_req_busy", i), {mem_req, busy}, {vecs[i].e_mem_req, vecs[i].e_busy});
            if (vecs[i].e_mem_req) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
                chk($sformatf("v%0d_mem_we_be_wdata", i), {mem_we, mem_be, mem_wdata},
                    {vecs[i].e_mem_we, vecs[i].e_mem_be, vecs[i].e_mem_wdata});
            end
        end

        // Starvation: data held continuously, fetch waiting
        ord_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; d_wdata = 0;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h11;
        n = 0; fdone = 0;
        for (int c = 0; c < 120 && n < 11; c++) begin
            @(negedge clk);
            sg_i = if_gnt; sg_d = d_gnt;
            if (sg_i || sg_d) begin
                ord[n] = sg_i;
                n++;
            end
            if (n < 11) begin
                @(posedge clk); #1;
                if (sg_i) begin if_req = 0; fdone = 1; end
                if (sg_d) begin d_addr = d_addr + 4; if (fdone) if_req = 1; end
            end
        end
        chk("starve_grant_count", n, 11);
        for (int i = 0; i < 11; i++)
            if (i < n) chk($sformatf("starve_order%0d", i), ord[i], ord_exp[i]);
        @(posedge clk); #1;
        if_req = 0; d_req = 0; mem_gnt = 0;
        repeat (2) @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        chk("starve_end_idle", busy, 1'b0);

        txn(0, 32'h30,  32'h12345678, 0, 0, 1, 0, 0, "flush_wait");
        txn(0, 32'h40,  32'h00000013, 0, 0, 0, 0, 1, "fetch_after_flush");
        txn(0, 32'h44,  32'h00000033, 0, 1, 0, 0, 0, "flush_req");
        txn(0, 32'h48,  32'h00000063, 0, 0, 0, 1, 0, "flush_same_cycle");
        txn(0, 32'h4C,  32'h00000073, 1, 0, 0, 0, 1, "flush_idle");
        txn(1, 32'h104, 32'hCAFEF00D, 0, 1, 1, 1, 1, "flush_data_owner");

        // Reset while a fetch waits for its response
        @(posedge clk); #1; if_req = 1; if_addr = 32'h60;
        @(posedge clk); #1; mem_gnt = 1;
        @(posedge clk); #1; if_req = 0; mem_gnt = 0;
        @(negedge clk);
        chk("rstmid_busy_before", busy, 1'b1);
        @(posedge clk); #1; reset_n = 0;
        @(posedge clk); #1; reset_n = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("rstmid_ctrl", {mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid}, 6'b0);
        chk("rstmid_bus", {mem_we, mem_be, mem_wdata}, 37'b0);
        chk("rstmid_addr", mem_addr, 32'h0);
        chk("rstmid_rdata", {if_rdata, d_rdata}, 64'h0);
        @(posedge clk); #1; mem_rvalid = 0;

        // Randomized traffic against the reference model
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        m_out = 0; m_own_d = 0; m_drop = 0; m_wins = 0;
        f_pend = 0; f_cool = 0; dp = 0; d_cool = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (!f_pend && !f_cool && $urandom_range(0, 2) == 0) begin
                f_pend = 1; f_a = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!dp && !d_cool && $urandom_range(0, 9) < 8) begin
                dp = 1; dw = 1'($urandom); dbe = 4'($urandom); da = $urandom; dwd = $urandom;
            end
            if_req = f_pend; if_addr = f_pend ? f_a : $urandom;
            d_req = dp; d_we = dw; d_be = dbe; d_addr = da; d_wdata = dwd;
            if_flush   = ($urandom_range(0, 6) == 0);
            mem_gnt    = (m_out == 1) && ($urandom_range(0, 1) == 1);
            mem_rvalid = (m_out == 2) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            mem_rdata  = $urandom;

            e_busy = (m_out != 0);
            e_req  = (m_out == 1);
            e_ig   = (m_out == 1) && mem_gnt && !m_own_d;
            e_dg   = (m_out == 1) && mem_gnt && m_own_d;
            e_ir   = (m_out == 2) && mem_rvalid && !m_own_d && !m_drop && !if_flush;
            e_dr   = (m_out == 2) && mem_rvalid && m_own_d;

            @(negedge clk);
            chk("rnd_ctrl", {mem_req, busy, if_gnt, d_gnt, if_rvalid, d_rvalid},
                {e_req, e_busy, e_ig, e_dg, e_ir, e_dr});
            chk("rnd_if_rdata", if_rdata, e_ir ? mem_rdata : 32'h0);
            chk("rnd_d_rdata", d_rdata, e_dr ? mem_rdata : 32'h0);
            if (e_req) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we_be_wdata", {mem_we, mem_be, mem_wdata}, {m_we, m_be, m_wdata});
            end

            f_cool = 0; d_cool = 0;
            if (e_ig) begin f_pend = 0; f_cool = 1; end
            if (e_dg) begin dp = 0; d_cool = 1; end
            case (m_out)
                0: begin
                    m_drop = 0;
                    if (d_req && !(if_req && m_wins == MAX_WAIT)) begin
                        m_own_d = 1; m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
                        m_wins = if_req ? m_wins + 1 : 0;
                        m_out = 1;
                    end else if (if_req) begin
                        m_own_d = 0; m_addr = if_addr; m_we = 0; m_be = 4'hF; m_wdata = 0;
                        m_wins = 0;
                        m_out = 1;
                    end else begin
                        m_wins = 0;
                    end
                end
                1: begin
                    if (if_flush && !m_own_d) m_drop = 1;
                    if (mem_gnt) m_out = 2;
                end
                default: begin
                    if (mem_rvalid) begin m_out = 0; m_drop = 0; end
                    else if (if_flush && !m_own_d) m_drop = 1;
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
